// File: rtl/ex_mc_pkg.sv
// ex_mc shared definitions: opcode map, FSM states, multi-cycle decode.
// Optional divider controlled by macro EX_MC_DIV_EN.
package ex_mc_pkg;

    // Add family: all variants produce op1 + op2
    localparam logic [4:0] OP_ADD_LD   = 5'b10001;
    localparam logic [4:0] OP_ADD_ST   = 5'b10010;
    localparam logic [4:0] OP_ADD_JAL  = 5'b10100;
    localparam logic [4:0] OP_ADD_JALR = 5'b10101;
    localparam logic [4:0] OP_ADDI     = 5'b01100;
    localparam logic [4:0] OP_ADD      = 5'b01101;

    localparam logic [4:0] OP_SUB      = 5'b01110;
    localparam logic [4:0] OP_XOR      = 5'b00110;
    localparam logic [4:0] OP_OR       = 5'b00101;
    localparam logic [4:0] OP_AND      = 5'b00100;
    localparam logic [4:0] OP_SRL      = 5'b01001;
    localparam logic [4:0] OP_SLL      = 5'b01010;
    localparam logic [4:0] OP_SRA      = 5'b01011;
    localparam logic [4:0] OP_SLT      = 5'b00111;
    localparam logic [4:0] OP_SLTU     = 5'b01000;

    localparam logic [4:0] OP_MUL      = 5'b11000;
    localparam logic [4:0] OP_MULHU    = 5'b11001;
    localparam logic [4:0] OP_DIVU     = 5'b11010;
    localparam logic [4:0] OP_REMU     = 5'b11011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes served by the iterative unit
    function automatic logic is_multicycle(input logic [4:0] op);
`ifdef EX_MC_DIV_EN
        return (op == OP_MUL) || (op == OP_MULHU) ||
               (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL) || (op == OP_MULHU);
`endif
    endfunction

endpackage

// File: rtl/ex_mc_muldiv.sv
// ex_mc iterative unit: shift-add multiply and restoring divide on one
// 2*XLEN accumulator, one bit per cycle. Divider built only with EX_MC_DIV_EN.
module ex_mc_muldiv
    import ex_mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] LAST = (SHW+1)'(XLEN - 1);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   bq;
    logic [4:0]        opq;
    logic [SHW:0]      cnt;
    logic              running;
    logic [XLEN:0]     sum;
    logic              hi_sel;
`ifdef EX_MC_DIV_EN
    logic [XLEN:0]     diff;
    logic              is_div;
`endif

    // Last step: result is taken from the accumulator value being produced
    assign done   = running && (cnt == LAST);
    assign hi_sel = (opq == OP_MULHU) || (opq == OP_REMU);
    assign result = hi_sel ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];

    // One iteration: add-and-shift-right for multiply, trial subtract for divide
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? bq : '0)};
        acc_nxt = {sum, acc[XLEN-1:1]};
`ifdef EX_MC_DIV_EN
        is_div = (opq == OP_DIVU) || (opq == OP_REMU);
        diff   = acc[2*XLEN-1:XLEN-1] - {1'b0, bq};
        if (is_div) begin
            if (!diff[XLEN])
                acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_nxt = {acc[2*XLEN-2:0], 1'b0};
        end
`endif
    end

    // Load operands on start, then step until the counter reaches XLEN-1
    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            bq      <= '0;
            opq     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, a};
            bq      <= b;
            opq     <= op;
        end else if (running) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_mc.sv
// ex_mc multi-cycle execute stage: operand muxes, single-cycle ALU, FSM.
// Define EX_MC_DIV_EN to include divu/remu in the iterative unit.
module ex_mc
    import ex_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic            alu_src1,
    input  logic            alu_src2,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      alu_op_o,
    output logic [XLEN-1:0] alu_out,
    output logic            busy
);

    state_t          state;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic            md_start;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    assign op1      = alu_src1 ? pc : rs1_data;
    assign op2      = alu_src2 ? imm : rs2_data;
    assign shamt    = op2[SHW-1:0];
    assign accept   = in_ready && in_valid;
    assign md_start = accept && is_multicycle(alu_op);

    // Single-cycle ALU; multi-cycle and unknown opcodes fall to zero
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD_LD, OP_ADD_ST, OP_ADD_JAL,
            OP_ADD_JALR, OP_ADDI, OP_ADD:
                alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_OR:   alu_res = op1 | op2;
            OP_AND:  alu_res = op1 & op2;
            OP_SRL:  alu_res = op1 >> shamt;
            OP_SLL:  alu_res = op1 << shamt;
            OP_SRA:  alu_res = $signed(op1) >>> shamt;
            OP_SLT:
                alu_res = {{(XLEN-1){1'b0}},
                           $signed(op1) < $signed(op2)};
            OP_SLTU:
                alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            default: alu_res = '0;
        endcase
    end

    ex_mc_muldiv #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (alu_op),
        .a     (op1),
        .b     (op2),
        .done  (md_done),
        .result(md_result)
    );

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            alu_out   <= '0;
            alu_op_o  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        alu_op_o <= alu_op;
                        if (is_multicycle(alu_op)) begin
                            state <= ST_BUSY;
                            busy  <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            alu_out   <= alu_res;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        alu_out   <= md_result;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
